// File: rtl/des_pkg.sv
// DES key-schedule constants and helpers: FIPS 46-3 permutation tables, the
// rotation schedule, and per-byte odd-parity checking.
package des_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam int unsigned NumRounds = 16;

  localparam int unsigned SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Entry j holds the FIPS key bit (1-based) feeding PC-1 output bit j+1.
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Entry i holds the C/D bit (1-based) feeding PC-2 output bit i+1.
  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Total left rotation applied after rounds 1..r.
  function automatic int unsigned cum_shift(input int unsigned r);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < NumRounds; i++) begin
      if (i < r) s += SHIFTS[i];
    end
    return s;
  endfunction

  function automatic logic shift_two(input int unsigned r);
    return (cum_shift(r) - cum_shift(r - 1)) == 2;
  endfunction

  function automatic logic odd_parity_ok(input logic [7:0] b);
    return ^b;
  endfunction

  // Rotate both 28-bit halves by one or two places; a left rotate moves bit i+1 into bit i.
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic two,
                                         input logic right);
    logic [27:0] c, d;
    c = cd[27:0];
    d = cd[55:28];
    if (right) begin
      c = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
      d = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
    end else begin
      c = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
      d = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
    end
    return {d, c};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2: selects 48 round-key bits from the 56-bit C/D state.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] rk_o
);

  for (genvar i = 0; i < 48; i++) begin : g_bit
    localparam int unsigned Src = PC2[i] - 1;
    assign rk_o[i] = cd_i[Src];
  end

endmodule

// File: rtl/des_key_sched.sv
// DES round-key generator: PC-1 on accept, then streams the 16 PC-2 round keys,
// KEYS_PER_BEAT per beat, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched
  import des_pkg::*;
#(
  parameter int unsigned KEYS_PER_BEAT = 1,
  parameter bit          PARITY_CHECK  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_valid_i,
  output logic                        key_ready_o,
  input  logic [63:0]                 key_i,
  input  logic                        decrypt_i,
  input  logic                        flush_i,
  output logic                        rk_valid_o,
  input  logic                        rk_ready_i,
  output logic [48*KEYS_PER_BEAT-1:0] rk_o,
  output logic [4:0]                  rk_round_o,
  output logic                        rk_last_o,
  output logic                        parity_err_o,
  output logic                        busy_o
);

  localparam int unsigned NumBeats = NumRounds / KEYS_PER_BEAT;

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  beat_q, beat_d;
  logic        dec_q, dec_d;
  logic        perr_q, perr_d;

  logic [55:0] cd_load;
  logic        key_par_err;
  logic        last_beat;
  logic [4:0]  round0;
  logic [55:0] stage  [KEYS_PER_BEAT+1];
  logic [55:0] pc2_in [KEYS_PER_BEAT];
  logic [47:0] lane_rk[KEYS_PER_BEAT];

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    localparam int unsigned Src = PC1[i] - 1;
    assign cd_load[i] = key_i[Src];
  end

  always_comb begin
    key_par_err = 1'b0;
    for (int unsigned j = 0; j < 8; j++) begin
      key_par_err |= !odd_parity_ok(key_i[8*j +: 8]);
    end
  end

  // Rotation chain: encrypt keys come after each rotate, decrypt keys before it.
  always_comb begin
    int unsigned base, r;
    base   = {28'd0, beat_q} * KEYS_PER_BEAT;
    r      = 0;
    round0 = '0;
    stage  = '{default: '0};
    pc2_in = '{default: '0};
    stage[0] = cd_q;
    for (int unsigned k = 0; k < KEYS_PER_BEAT; k++) begin
      r = dec_q ? NumRounds - base - k : base + k + 1;
      if (k == 0) round0 = r[4:0];
      stage[k+1] = rot_cd(stage[k], shift_two(r), dec_q);
      pc2_in[k]  = dec_q ? stage[k] : stage[k+1];
    end
  end

  for (genvar k = 0; k < KEYS_PER_BEAT; k++) begin : g_lane
    des_pc2 u_pc2 (
      .cd_i (pc2_in[k]),
      .rk_o (lane_rk[k])
    );
  end

  assign last_beat = (beat_q == 4'(NumBeats - 1));

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    beat_d  = beat_q;
    dec_d   = dec_q;
    perr_d  = perr_q;
    unique case (state_q)
      StIdle: begin
        if (key_valid_i) begin
          state_d = StRun;
          cd_d    = cd_load;
          beat_d  = '0;
          dec_d   = decrypt_i;
          perr_d  = PARITY_CHECK && key_par_err;
        end
      end
      StRun: begin
        // Flush wins over a same-cycle handshake.
        if (flush_i) begin
          state_d = StIdle;
        end else if (rk_ready_i) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 4'd1;
            cd_d   = stage[KEYS_PER_BEAT];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cd_q    <= '0;
      beat_q  <= '0;
      dec_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      beat_q  <= beat_d;
      dec_q   <= dec_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    rk_o       = '0;
    rk_round_o = '0;
    rk_last_o  = 1'b0;
    if (state_q == StRun) begin
      for (int unsigned k = 0; k < KEYS_PER_BEAT; k++) begin
        rk_o[48*k +: 48] = lane_rk[k];
      end
      rk_round_o = round0;
      rk_last_o  = last_beat;
    end
  end

  assign rk_valid_o   = (state_q == StRun);
  assign busy_o       = (state_q == StRun);
  assign key_ready_o  = (state_q == StIdle);
  assign parity_err_o = perr_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: one instance at 1 key/beat, one at 4 keys/beat,
// checked against a direct FIPS key-schedule model.
module tb_des_key_sched;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [191:0] rk;
    logic [4:0]   round;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, dec, kv1, kv4, flush1;
  logic         rdy1 = 1'b1, rdy4 = 1'b1;
  logic [63:0]  key;
  logic         kr1, kr4, v1, v4, last1, last4, perr1, perr4, busy1, busy4;
  logic [47:0]  rk1;
  logic [191:0] rk4;
  logic [4:0]   rnd1, rnd4;

  des_key_sched #(.KEYS_PER_BEAT(1), .PARITY_CHECK(1'b1)) dut1 (
    .clk (clk), .rst_n (rst_n), .key_valid_i (kv1), .key_ready_o (kr1), .key_i (key),
    .decrypt_i (dec), .flush_i (flush1), .rk_valid_o (v1), .rk_ready_i (rdy1), .rk_o (rk1),
    .rk_round_o (rnd1), .rk_last_o (last1), .parity_err_o (perr1), .busy_o (busy1)
  );

  des_key_sched #(.KEYS_PER_BEAT(4), .PARITY_CHECK(1'b0)) dut4 (
    .clk (clk), .rst_n (rst_n), .key_valid_i (kv4), .key_ready_o (kr4), .key_i (key),
    .decrypt_i (dec), .flush_i (1'b0), .rk_valid_o (v4), .rk_ready_i (rdy4), .rk_o (rk4),
    .rk_round_o (rnd4), .rk_last_o (last4), .parity_err_o (perr4), .busy_o (busy4)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit bp_en = 1'b0;

  logic [47:0]  mk [1:16];
  beat_t        q1[$], q4[$];
  logic [47:0]  obs1[$];
  logic [4:0]   obs1_rnd[$];
  logic [191:0] obs4[$];
  logic [4:0]   obs4_rnd[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  function automatic logic [47:0] rev48(input logic [47:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = x[47-i];
    return r;
  endfunction

  function automatic bit par_bad(input logic [63:0] kb);
    for (int j = 0; j < 8; j++) begin
      if ($countones(kb[8*j +: 8]) % 2 == 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Textbook schedule: PC-1, rotate C and D one place at a time, PC-2.
  task automatic model_keys(input logic [63:0] kb);
    int c [28];
    int d [28];
    int t [28];
    int p;
    for (int j = 0; j < 28; j++) begin
      c[j] = int'(kb[PC1_T[j] - 1]);
      d[j] = int'(kb[PC1_T[j+28] - 1]);
    end
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < SH_T[r-1]; s++) begin
        t = c;
        for (int j = 0; j < 28; j++) c[j] = t[(j + 1) % 28];
        t = d;
        for (int j = 0; j < 28; j++) d[j] = t[(j + 1) % 28];
      end
      for (int i = 0; i < 48; i++) begin
        p = PC2_T[i];
        mk[r][i] = (p <= 28) ? (c[p-1] != 0) : (d[p-29] != 0);
      end
    end
  endtask

  task automatic push_exp(input int lanes, input logic d);
    beat_t b;
    int idx, r;
    for (int bi = 0; bi < 16 / lanes; bi++) begin
      b = '0;
      for (int k = 0; k < lanes; k++) begin
        idx = bi * lanes + k;
        r = d ? 16 - idx : idx + 1;
        b.rk[48*k +: 48] = mk[r];
        if (k == 0) b.round = 5'(r);
      end
      b.last = (bi == 16 / lanes - 1);
      if (lanes == 1) q1.push_back(b);
      else q4.push_back(b);
    end
  endtask

  // Called #1 after a posedge with both instances idle.
  task automatic issue(input logic [63:0] k, input logic d, input bit to1, input bit to4);
    bit pb;
    model_keys(k);
    pb  = par_bad(k);
    key = k;
    dec = d;
    kv1 = to1;
    kv4 = to4;
    @(posedge clk);
    #1;
    kv1 = 1'b0;
    kv4 = 1'b0;
    key = {$urandom, $urandom};
    dec = 1'($urandom_range(0, 1));
    if (to1) begin
      push_exp(1, d);
      check("parity1", 192'(perr1), 192'(pb));
    end
    if (to4) begin
      push_exp(4, d);
      check("parity4_disabled", 192'(perr4), 192'(1'b0));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((q1.size() != 0 || q4.size() != 0) && n < 300);
    if (q1.size() != 0 || q4.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: %0d/%0d beats still pending after %0d cycles", q1.size(),
               q4.size(), n);
      q1.delete();
      q4.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    rdy1 = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    rdy4 = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  beat_t       e1, e4;
  bit          stall1 = 1'b0, stall4 = 1'b0;
  logic [47:0] h_rk1;
  logic [4:0]  h_rnd1, h_rnd4;
  logic        h_last1, h_last4;
  logic [191:0] h_rk4;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall1 = 1'b0;
    end else begin
      check("valid1", 192'(v1), 192'(q1.size() != 0));
      check("key_ready1", 192'(kr1), 192'(q1.size() == 0));
      if (v1 && stall1) begin
        check("stall_rk1", 192'(rk1), 192'(h_rk1));
        check("stall_round1", 192'(rnd1), 192'(h_rnd1));
        check("stall_last1", 192'(last1), 192'(h_last1));
      end
      stall1  = v1 && !rdy1 && !flush1;
      h_rk1   = rk1;
      h_rnd1  = rnd1;
      h_last1 = last1;
      if (v1 && (rdy1 || flush1) && q1.size() != 0) begin
        e1 = q1.pop_front();
        check("rk1", 192'(rk1), 192'(e1.rk[47:0]));
        check("round1", 192'(rnd1), 192'(e1.round));
        check("last1", 192'(last1), 192'(e1.last));
        if (rdy1) begin
          obs1.push_back(rk1);
          obs1_rnd.push_back(rnd1);
        end
        if (flush1) q1.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall4 = 1'b0;
    end else begin
      check("valid4", 192'(v4), 192'(q4.size() != 0));
      check("key_ready4", 192'(kr4), 192'(q4.size() == 0));
      if (v4 && stall4) begin
        check("stall_rk4", rk4, h_rk4);
        check("stall_round4", 192'(rnd4), 192'(h_rnd4));
        check("stall_last4", 192'(last4), 192'(h_last4));
      end
      stall4  = v4 && !rdy4;
      h_rk4   = rk4;
      h_rnd4  = rnd4;
      h_last4 = last4;
      if (v4 && rdy4 && q4.size() != 0) begin
        e4 = q4.pop_front();
        check("rk4", rk4, e4.rk);
        check("round4", 192'(rnd4), 192'(e4.round));
        check("last4", 192'(last4), 192'(e4.last));
        obs4.push_back(rk4);
        obs4_rnd.push_back(rnd4);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_key_ready1"}, 192'(kr1), 192'(1'b1));
    check({tag, "_valid1"}, 192'(v1), 192'(1'b0));
    check({tag, "_rk1"}, 192'(rk1), 192'(0));
    check({tag, "_round1"}, 192'(rnd1), 192'(0));
    check({tag, "_last1"}, 192'(last1), 192'(1'b0));
    check({tag, "_parity1"}, 192'(perr1), 192'(1'b0));
    check({tag, "_busy1"}, 192'(busy1), 192'(1'b0));
    check({tag, "_key_ready4"}, 192'(kr4), 192'(1'b1));
    check({tag, "_valid4"}, 192'(v4), 192'(1'b0));
    check({tag, "_rk4"}, rk4, 192'(0));
    check({tag, "_busy4"}, 192'(busy4), 192'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] kat_key, bad_key;
    logic [47:0] k1, k2, k16;
    kat_key = rev64(64'h133457799BBCDFF1);
    bad_key = rev64(64'h123457799BBCDFF1);
    k1  = rev48(48'h1B02EFFC7072);
    k2  = rev48(48'h79AED9DBC9E5);
    k16 = rev48(48'hCB3D8B0E17F5);
    rst_n = 1'b0;
    key = '0;
    dec = 1'b0;
    kv1 = 1'b0;
    kv4 = 1'b0;
    flush1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Encrypt known-answer, 1 key per beat.
    obs1.delete(); obs1_rnd.delete();
    issue(kat_key, 1'b0, 1'b1, 1'b0);
    wait_idle();
    check("enc_beats", 192'(obs1.size()), 192'(16));
    if (obs1.size() == 16) begin
      check("enc_k1", 192'(obs1[0]), 192'(k1));
      check("enc_k1_round", 192'(obs1_rnd[0]), 192'(1));
      check("enc_k2", 192'(obs1[1]), 192'(k2));
      check("enc_k16", 192'(obs1[15]), 192'(k16));
    end

    // Decrypt known-answer.
    obs1.delete(); obs1_rnd.delete();
    issue(kat_key, 1'b1, 1'b1, 1'b0);
    wait_idle();
    check("dec_beats", 192'(obs1.size()), 192'(16));
    if (obs1.size() == 16) begin
      check("dec_first", 192'(obs1[0]), 192'(k16));
      check("dec_first_round", 192'(obs1_rnd[0]), 192'(16));
      check("dec_last", 192'(obs1[15]), 192'(k1));
      check("dec_last_round", 192'(obs1_rnd[15]), 192'(1));
    end

    // Four keys per beat.
    obs4.delete(); obs4_rnd.delete();
    issue(kat_key, 1'b0, 1'b0, 1'b1);
    wait_idle();
    check("kpb4_beats", 192'(obs4.size()), 192'(4));
    if (obs4.size() == 4) begin
      check("kpb4_lane0", 192'(obs4[0][47:0]), 192'(k1));
      check("kpb4_lane1", 192'(obs4[0][95:48]), 192'(k2));
      for (int i = 0; i < 4; i++) check("kpb4_round", 192'(obs4_rnd[i]), 192'(4 * i + 1));
    end

    // Random backpressure on the known-answer key.
    bp_en = 1'b1;
    obs1.delete(); obs1_rnd.delete();
    issue(kat_key, 1'b0, 1'b1, 1'b0);
    wait_idle();
    bp_en = 1'b0;
    check("bp_beats", 192'(obs1.size()), 192'(16));

    // Bad parity: flagged, held, keys still produced.
    obs1.delete(); obs1_rnd.delete();
    issue(bad_key, 1'b0, 1'b1, 1'b0);
    check("parity_bad_flag", 192'(perr1), 192'(1'b1));
    wait_idle();
    check("parity_held", 192'(perr1), 192'(1'b1));
    check("parity_key_beats", 192'(obs1.size()), 192'(16));

    // Flush on beat 5, then restart with flush held during the accept.
    issue(kat_key, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    flush1 = 1'b1;
    @(posedge clk);
    #1;
    flush1 = 1'b0;
    check("flush_idle_valid", 192'(v1), 192'(1'b0));
    check("flush_idle_ready", 192'(kr1), 192'(1'b1));
    obs1.delete(); obs1_rnd.delete();
    flush1 = 1'b1;
    issue(kat_key, 1'b0, 1'b1, 1'b0);
    flush1 = 1'b0;
    wait_idle();
    check("restart_beats", 192'(obs1.size()), 192'(16));
    if (obs1.size() != 0) check("restart_k1", 192'(obs1[0]), 192'(k1));

    // Random keys and modes on both instances with backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      wait_idle();
    end
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-run.
    issue(bad_key, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q1.delete();
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(kat_key, 1'b1, 1'b1, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Parametrised DES round-key generator: accepts a 64-bit key, applies PC-1, runs the 28+28-bit C/D rotation schedule, and streams the 16 PC-2 round keys over a valid/ready interface, KEYS_PER_BEAT keys per beat. Encrypt order is K1..K16 and decrypt order is K16..K1, selected per key. It optionally checks the per-byte odd parity dropped by PC-1. It sits between key storage and the DES round datapath.

## Interface
- KEYS_PER_BEAT, 1, round keys per output beat; legal values 1, 2, 4, 8, 16.
- PARITY_CHECK, 1, 1 enables the parity checker; 0 ties parity_err_o low.
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid_i  in  1  key offered.
- key_ready_o  out  1  block can accept a key.
- key_i  in  64  key; bus index n-1 holds FIPS key bit n (index 0 = FIPS bit 1).
- decrypt_i  in  1  sampled with the key; 1 selects K16..K1 order.
- flush_i  in  1  synchronous abort of the current key.
- rk_valid_o  out  1  beat valid.
- rk_ready_i  in  1  consumer accepts the beat.
- rk_o  out  48*KEYS_PER_BEAT  lane k at [48k+:48] is the k-th key in emit order; lane bit i = PC-2 output bit i+1.
- rk_round_o  out  5  FIPS round number (1..16) of lane 0.
- rk_last_o  out  1  final beat of this key.
- parity_err_o  out  1  registered result of the last accepted key's parity check.
- busy_o  out  1  high in RUN.

## Operation
- States: IDLE and RUN.
- IDLE:
  - key_ready_o=1, rk_valid_o=0.
  - On key_valid_i&&key_ready_o: register CD = PC-1(key_i) with C = bits [27:0] and D = bits [55:28], register mode, clear the beat counter, and go to RUN.
- Rotation in FIPS terms uses the shift schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - A FIPS left rotate moves bit 2 into bit 1, so in index terms C_new[i] = C[(i+1) mod 28].
  - The same rule applies to D.
- Encrypt:
  - Key r = PC-2 of CD rotated left by cumulative shift(1..r).
  - The register holds CD after the last emitted round.
- Decrypt:
  - The first key is K16 = PC-2(CD0), with no rotation.
  - After emitting Kr, rotate right by shift(r).
- Each beat chains KEYS_PER_BEAT rotation+PC-2 stages combinationally from the CD register.
  - On handshake, CD advances by the whole beat.
  - The number of beats is 16/KEYS_PER_BEAT.
- RUN:
  - rk_valid_o=1 and key_ready_o=0.
  - rk_o, rk_round_o and rk_last_o stay stable while rk_valid_o&&!rk_ready_i.
  - The handshake on the beat with rk_last_o=1 returns the block to IDLE.
- flush_i:
  - In RUN, the block goes to IDLE on the next edge and drops the remaining beats.
  - flush_i takes priority over a simultaneous handshake; that beat counts as consumed.
  - In IDLE, flush_i is ignored; the same-cycle key accept proceeds.
- Parity:
  - Byte j is key_i[8j+7:8j] and must hold an odd number of ones.
  - parity_err_o = OR of all byte failures, registered at accept and held until the next accept.
  - Keys with a parity error are still expanded normally.
- rk_o, rk_round_o and rk_last_o are driven to 0 whenever rk_valid_o=0.

## Timing
- Reset values: key_ready_o=1, rk_valid_o=0, rk_o=0, rk_round_o=0, rk_last_o=0, parity_err_o=0, busy_o=0, state IDLE.
- rst_n asserted mid-RUN forces these values immediately; no partial beat survives.
- Latency: the first rk_valid_o is in the cycle after the key accept.
- With rk_ready_i held at 1, a key takes 16/KEYS_PER_BEAT cycles.
- key_ready_o returns the cycle after the last handshake, so the key rate is one per 1+16/KEYS_PER_BEAT cycles.
- No combinational path from key_valid_i or rk_ready_i to any output.
- The path from the CD register to rk_o is KEYS_PER_BEAT rotations deep plus PC-2; this is accepted.

## Structure
- Package des_pkg holds:
  - the shift schedule;
  - the PC-1 and PC-2 index tables;
  - a cumulative-shift function;
  - an odd-parity byte check function.
- Sub-module des_pc2 is a purely combinational 56->48 PC-2 block, instantiated once per lane.
- Top level contains the FSM, the CD register, the beat counter, the mode flag and the parity register.

## Test plan
All hex values below are FIPS MSB-first; the bench bit-reverses them onto the buses.
- Encrypt, KEYS_PER_BEAT=1:
  - Stimulus: key 133457799BBCDFF1 with rk_ready_i=1.
  - Required: 16 beats; beat 1 = 1B02EFFC7072 with round 1; beat 2 = 79AED9DBC9E5; beat 16 = CB3D8B0E17F5 with rk_last_o=1; parity_err_o=0.
- Decrypt, same key:
  - Required: beat 1 = CB3D8B0E17F5 with round 16; last beat = 1B02EFFC7072 with round 1.
- KEYS_PER_BEAT=4, encrypt:
  - Required: 4 beats; lane 0 of beat 1 = K1, lane 1 = K2; rk_round_o sequence 1,5,9,13; rk_last_o only on beat 4.
- Backpressure:
  - Stimulus: rk_ready_i toggles randomly.
  - Required: rk_o is stable during stalls; the key sequence is identical to the first scenario; key_ready_o=0 throughout.
- Parity:
  - Stimulus: key 123457799BBCDFF1.
  - Required: parity_err_o=1 from the cycle after accept; subkeys are still produced.
- Flush and reset:
  - Stimulus: flush_i on beat 5.
  - Required: IDLE next cycle; the next key restarts at K1.
  - Stimulus: rst_n low mid-RUN.
  - Required: outputs take their reset values asynchronously.
